// File: rtl/logic_gates_checker.sv
// Sequential self-test driver for a two-input, seven-output gate block.
// It steps a/b through 00,01,10,11, lets each vector settle, and scores y against the golden truth table.
module logic_gates_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic       a_n, b_n, busy_n, done_n, pass_n;
  logic [6:0] fail_mask_n;
  logic [2:0] err_count_n;
  logic [6:0] golden;
  logic [6:0] diff;

  // Output order is {XNOR, XOR, NOR, NAND, NOT-a, OR, AND}.
  always_comb begin
    golden = 7'h5C;
    case (idx)
      2'd0: golden = 7'h5C;
      2'd1: golden = 7'h2E;
      2'd2: golden = 7'h2A;
      2'd3: golden = 7'h43;
      default: golden = 7'h5C;
    endcase
  end

  assign diff = y ^ golden;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    a_n         = a;
    b_n         = b;
    busy_n      = busy;
    done_n      = 1'b0;
    pass_n      = pass;
    fail_mask_n = fail_mask;
    err_count_n = err_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SETTLE;
          idx_n       = 2'd0;
          a_n         = 1'b0;
          b_n         = 1'b0;
          cnt_n       = 8'd0;
          busy_n      = 1'b1;
          pass_n      = 1'b0;
          fail_mask_n = 7'd0;
          err_count_n = 3'd0;
        end
      end
      SETTLE: begin
        cnt_n = cnt + 8'd1;
        if (cnt == SETTLE_LAST) state_n = SAMPLE;
      end
      SAMPLE: begin
        fail_mask_n = fail_mask | diff;
        err_count_n = err_count + {2'b00, |diff};
        if (idx != 2'd3) begin
          idx_n   = idx + 2'd1;
          a_n     = idx_n[1];
          b_n     = idx_n[0];
          cnt_n   = 8'd0;
          state_n = SETTLE;
        end else begin
          // pass/done are registered on the DONE-entry edge so they appear together.
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (fail_mask_n == 7'd0);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 7'd0;
      err_count <= 3'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      a         <= a_n;
      b         <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      fail_mask <= fail_mask_n;
      err_count <= err_count_n;
    end
  end

  assign fsm_state = state;

endmodule

// File: doc/logic_gates_checker.md
# logic_gates_checker

Sequential self-test driver for the seven-output two-input gate block (AND, OR, NOT-a, NAND, NOR, XOR, XNOR). On a start request it drives all four input combinations onto the gate block's `a`/`b` and waits a programmable settle time. It then samples the seven gate outputs and compares them against the golden truth table. A pass flag, a per-output failure mask and a failing-vector count are reported with a one-cycle done pulse. It sits between board-level control (button or host register) and the gate block.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling `y`. Legal range is 1..255; 8-bit settle counter.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled only in IDLE.
- `a` out 1: drives gate block input a.
- `b` out 1: drives gate block input b.
- `y` in 7: gate block outputs packed `{y6,y5,y4,y3,y2,y1,y0}`.
- `busy` out 1: high from the start-accept edge until DONE is entered.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: 1 when the last run had no mismatches.
- `fail_mask` out 7: bit i set if `yi` mismatched on any vector of the last run.
- `err_count` out 3: number of vectors (0..4) with at least one mismatch.

## Operation
- Vector index `idx` (2 bits) drives `a = idx[1]`, `b = idx[0]`. Order is 0,1,2,3.
- Golden `y[6:0]` per idx: idx0 = 7'h5C, idx1 = 7'h2E, idx2 = 7'h2A, idx3 = 7'h43.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE → SETTLE** on `start` = 1. Same edge:
  - `idx` ← 0, `a`/`b` ← 0, settle count ← 0, `busy` ← 1.
  - `fail_mask`, `err_count`, `pass` ← 0.
- **SETTLE:** count increments each cycle. Go to SAMPLE when count = `SETTLE_CYCLES`−1, so SETTLE lasts exactly `SETTLE_CYCLES` cycles.
- **SAMPLE** (one cycle). At its closing edge:
  - `fail_mask` ← `fail_mask` | (`y` ^ golden[idx]).
  - `err_count` increments if (`y` ^ golden[idx]) ≠ 0.
  - If idx < 3: idx increments, `a`/`b` update to the new idx, count ← 0, go to SETTLE.
  - If idx = 3: go to DONE.
- **DONE** (one cycle): `done` = 1, `busy` = 0, `pass` = (`fail_mask` = 0). Next state is IDLE.
- `pass`, `fail_mask` and `err_count` hold until the next accepted start.
- `a`/`b` hold their last value (1,1) in IDLE after a run.
- `start` outside IDLE is ignored. No queuing. A `start` held high in IDLE after DONE begins a new run.
- `y` is treated as combinational from `a`/`b`. The checker adds no synchronizers.

## Timing
- Reset values: state IDLE, idx 0, `a` 0, `b` 0, `busy` 0, `done` 0, `pass` 0, `fail_mask` 0, `err_count` 0, settle count 0.
- `rst` overrides everything, including mid-run; the run is abandoned with no done pulse.
- Latency: start accepted at edge k; `done` is high in the cycle following edge k + 4·(`SETTLE_CYCLES`+1).
  - `SETTLE_CYCLES` = 2: 12 cycles.
  - `SETTLE_CYCLES` = 1: 8 cycles.
- The new `a`/`b` are visible from the edge that enters SETTLE for each vector.
- `y` is sampled at the edge ending SAMPLE, i.e. `SETTLE_CYCLES`+1 edges after `a`/`b` changed.
- `busy` and `done` are never high together. `done` is exactly one cycle wide.
- `err_count` saturates naturally at 4 (max vectors). 3 bits, no overflow.
- All outputs are registered.

## Test plan
- Correct gate model attached, `SETTLE_CYCLES` = 2, pulse `start`:
  - `a`/`b` step 00, 01, 10, 11, each held 3 cycles.
  - `done` 12 cycles after the start edge, `pass` = 1, `fail_mask` = 0, `err_count` = 0.
- `y3` stuck at 0 → `pass` = 0, `fail_mask` = 7'b0001000, `err_count` = 3.
- `y5` inverted (XOR output wrong on every vector) → `fail_mask` = 7'b0100000, `err_count` = 4.
- `a`/`b` swapped at the model input → NOT-a (`y2`) wrong on idx1 and idx2 → `fail_mask` = 7'b0000100, `err_count` = 2.
- `start` re-pulsed at cycles 3 and 7 of a run → ignored. Single `done` at cycle 12. Results are from the first run only.
- `rst` asserted at cycle 5 of a run → next cycle `busy` = 0, `a` = `b` = 0, no `done`, all results 0. A following `start` completes normally in 12 cycles.
- `SETTLE_CYCLES` = 1 build → `done` 8 cycles after start, same results as the first scenario.
